// File: rtl/spi_ctrl_fsm.sv
// spi_ctrl_fsm: SPI mode-0 transfer engine between the SPI control register and the SPI data memory.
// Build option SPI_LOOPBACK_EN: received bits are taken from the transmit path and miso_i is ignored.
module spi_ctrl_fsm #(
  parameter int CLK_DIV = 5,
  parameter int ADDR_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [31:0]       ctrl_i,
  output logic [31:0]       ctrl_o,
  output logic              ctrl_we_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [7:0]        dat_i,
  output logic [7:0]        dat_o,
  output logic              we_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_o,
  output logic              busy_o
);

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]      KEEP_MASK = 32'hFC00_FFFE;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      ctrl_q, ctrl_d;
  logic [9:0]       cnt_q, cnt_d;
  logic             load_q, load_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       half_q, half_d;
  logic             sclk_q, sclk_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             cs_q, cs_d;
  logic             miso_s;

`ifdef SPI_LOOPBACK_EN
  // In SHIFT mosi_o is exactly tx_q[7], so loop the shift register MSB back directly.
  assign miso_s = tx_q[7];
`else
  logic miso_meta_q, miso_meta_d;
  logic miso_sync_q, miso_sync_d;

  assign miso_meta_d = miso_i;
  assign miso_sync_d = miso_meta_q;
  assign miso_s      = miso_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= miso_meta_d;
      miso_sync_q <= miso_sync_d;
    end
  end
`endif

  assign cs_d   = ~ctrl_i[1];
  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      div_q   <= '0;
      half_q  <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    div_d     = div_q;
    half_d    = half_q;
    sclk_d    = sclk_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ctrl_o    = '0;
    ctrl_we_o = 1'b0;
    addr_o    = '0;
    dat_o     = '0;
    we_o      = 1'b0;
    mosi_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_i[0]) begin
          ctrl_d  = ctrl_i;
          cnt_d   = '0;
          load_d  = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        addr_o = ADDR_W'(cnt_q);
        if (!load_q) begin
          load_d = 1'b1;
        end else begin
          // The memory read issued in the first LOAD cycle returns now.
          if (ctrl_q[2])      tx_d = 8'hFF;
          else if (ctrl_q[3]) tx_d = 8'h00;
          else                tx_d = dat_i;
          load_d  = 1'b0;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        mosi_o = tx_q[7];
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          half_d = half_q + 4'd1;
          // Low half ending means a rising edge: sample. High half ending: falling edge, shift.
          if (!sclk_q) rx_d = {rx_q[6:0], miso_s};
          else         tx_d = {tx_q[6:0], 1'b0};
          if (half_q == 4'd15) state_d = STORE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      STORE: begin
        we_o      = 1'b1;
        addr_o    = ADDR_W'(cnt_q);
        dat_o     = rx_q;
        ctrl_we_o = 1'b1;
        ctrl_o    = (ctrl_q & KEEP_MASK) | {6'd0, cnt_q + 10'd1, 16'h0001};
        cnt_d     = cnt_q + 10'd1;
        state_d   = (cnt_q == {1'b0, ctrl_q[12:4]}) ? DONE : LOAD;
      end

      DONE: begin
        ctrl_we_o = 1'b1;
        ctrl_o    = (ctrl_q & KEEP_MASK) | {6'd0, {1'b0, ctrl_q[12:4]} + 10'd1, 16'h0000};
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// tb_spi_ctrl_fsm: randomized bench for spi_ctrl_fsm against a cycle-index model of each transfer,
// plus a CLK_DIV=1 instance for SCLK timing. Honours SPI_LOOPBACK_EN for expected receive data.
module tb_spi_ctrl_fsm;

  localparam int CD = 5;
  localparam int P  = 3 + 16 * CD;

`ifdef SPI_LOOPBACK_EN
  localparam bit         LOOPBACK   = 1'b1;
  localparam logic [7:0] EXP_SINGLE = 8'hA5;
  localparam logic [7:0] EXP_RX2    = 8'hA5;
`else
  localparam bit         LOOPBACK   = 1'b0;
  localparam logic [7:0] EXP_SINGLE = 8'h3C;
  localparam logic [7:0] EXP_RX2    = 8'hFF;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst;
  logic [31:0] ctrl_i, ctrl_o;
  logic        ctrl_we_o;
  logic [8:0]  addr_o;
  logic [7:0]  dat_i, dat_o;
  logic        we_o, sclk_o, mosi_o, miso_i, cs_o, busy_o;

  logic [31:0] ctrl2_i, ctrl2_o;
  logic        ctrl2_we_o;
  logic [8:0]  addr2_o;
  logic [7:0]  dat2_i, dat2_o;
  logic        we2_o, sclk2_o, mosi2_o, miso2_i, cs2_o, busy2_o;

  spi_ctrl_fsm #(.CLK_DIV(CD), .ADDR_W(9)) dut (
    .clk_i(clk_i), .rst(rst), .ctrl_i(ctrl_i), .ctrl_o(ctrl_o), .ctrl_we_o(ctrl_we_o),
    .addr_o(addr_o), .dat_i(dat_i), .dat_o(dat_o), .we_o(we_o), .sclk_o(sclk_o),
    .mosi_o(mosi_o), .miso_i(miso_i), .cs_o(cs_o), .busy_o(busy_o)
  );

  spi_ctrl_fsm #(.CLK_DIV(1), .ADDR_W(9)) dut2 (
    .clk_i(clk_i), .rst(rst), .ctrl_i(ctrl2_i), .ctrl_o(ctrl2_o), .ctrl_we_o(ctrl2_we_o),
    .addr_o(addr2_o), .dat_i(dat2_i), .dat_o(dat2_o), .we_o(we2_o), .sclk_o(sclk2_o),
    .mosi_o(mosi2_o), .miso_i(miso2_i), .cs_o(cs2_o), .busy_o(busy2_o)
  );

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Data memory with a one-cycle registered read, plus write-back of received bytes.
  logic [7:0] mem [512];
  logic [8:0] raddr = '0;
  always @(negedge clk_i) begin
    dat_i = mem[raddr];
    raddr = addr_o;
    if (we_o) mem[addr_o] = dat_o;
  end

  // Mode-0 slave: next bit presented after every falling SCLK edge, next byte after each store.
  logic [7:0] miso_bytes [512];
  int         sidx = 0;
  logic [7:0] slv = '0;
  logic       slv_sclk_prev = 1'b0;
  always @(negedge clk_i) begin
    if (!busy_o) begin
      sidx = 0;
      slv  = miso_bytes[0];
    end else if (we_o) begin
      sidx = sidx + 1;
      slv  = miso_bytes[sidx % 512];
    end else if (slv_sclk_prev && !sclk_o) begin
      slv = {slv[6:0], 1'b0};
    end
    slv_sclk_prev = sclk_o;
    miso_i = slv[7];
  end

  // Reference model: a transfer is described only by the cycle index since send was seen.
  bit          act_m = 1'b0;
  int          t_m, n_m, b_m, o_m, h_m;
  logic [31:0] ctrl_m, exp_ctrl, c_s;
  logic        r_s;
  logic [7:0]  tx_m [512];
  logic [7:0]  rx_m [512];
  logic [31:0] wb_q [$];
  int          busy_cnt, ones_cnt, zeros_cnt;
  logic [7:0]  mosi_cap;
  logic        sclk_seen = 1'b0;

  always @(posedge clk_i) begin
    r_s = rst;
    c_s = ctrl_i;
    if (!r_s) begin
      act_m = 1'b0;
    end else if (act_m) begin
      t_m++;
      if (t_m > n_m * P) act_m = 1'b0;
    end else if (c_s[0]) begin
      act_m  = 1'b1;
      t_m    = 0;
      ctrl_m = c_s;
      n_m    = int'(c_s[12:4]) + 1;
      for (int i = 0; i < n_m; i++) begin
        tx_m[i] = c_s[2] ? 8'hFF : (c_s[3] ? 8'h00 : mem[i]);
        rx_m[i] = LOOPBACK ? tx_m[i] : miso_bytes[i];
      end
    end
    #1;
    if (!r_s) begin
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_sclk", sclk_o, 0);
      checkOutput("rst_we", we_o, 0);
      checkOutput("rst_ctrl_we", ctrl_we_o, 0);
      checkOutput("rst_cs", cs_o, 1);
      checkOutput("rst_ctrl_o", ctrl_o, 0);
      checkOutput("rst_addr", addr_o, 0);
      checkOutput("rst_dat", dat_o, 0);
      checkOutput("rst_mosi", mosi_o, 0);
    end else begin
      checkOutput("cs_o", cs_o, {31'd0, ~c_s[1]});
      if (act_m) begin
        busy_cnt++;
        checkOutput("busy", busy_o, 1);
        if (t_m < n_m * P) begin
          b_m = t_m / P;
          o_m = t_m % P;
          if (o_m < 2) begin
            checkOutput("load_addr", addr_o, b_m % 512);
            checkOutput("load_sclk", sclk_o, 0);
            checkOutput("load_we", we_o, 0);
            checkOutput("load_ctrl_we", ctrl_we_o, 0);
          end else if (o_m < P - 1) begin
            h_m = (o_m - 2) / CD;
            checkOutput("shift_sclk", sclk_o, h_m % 2);
            checkOutput("shift_mosi", mosi_o, {31'd0, tx_m[b_m][7 - h_m / 2]});
            checkOutput("shift_we", we_o, 0);
            checkOutput("shift_ctrl_we", ctrl_we_o, 0);
            if (mosi_o) ones_cnt++;
            else        zeros_cnt++;
            if (sclk_o && !sclk_seen) mosi_cap = {mosi_cap[6:0], mosi_o};
          end else begin
            exp_ctrl        = ctrl_m;
            exp_ctrl[25:16] = 10'(b_m + 1);
            exp_ctrl[0]     = 1'b1;
            checkOutput("store_we", we_o, 1);
            checkOutput("store_addr", addr_o, b_m % 512);
            checkOutput("store_dat", dat_o, rx_m[b_m]);
            checkOutput("store_sclk", sclk_o, 0);
            checkOutput("store_ctrl_we", ctrl_we_o, 1);
            checkOutput("store_ctrl_o", ctrl_o, exp_ctrl);
          end
        end else begin
          exp_ctrl        = ctrl_m;
          exp_ctrl[25:16] = 10'(n_m);
          exp_ctrl[0]     = 1'b0;
          checkOutput("done_we", we_o, 0);
          checkOutput("done_sclk", sclk_o, 0);
          checkOutput("done_ctrl_we", ctrl_we_o, 1);
          checkOutput("done_ctrl_o", ctrl_o, exp_ctrl);
        end
      end else begin
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_sclk", sclk_o, 0);
        checkOutput("idle_we", we_o, 0);
        checkOutput("idle_ctrl_we", ctrl_we_o, 0);
      end
      if (ctrl_we_o) wb_q.push_back(ctrl_o);
    end
    sclk_seen = sclk_o;
  end

  // SCLK timing monitor for the CLK_DIV=1 instance (constant 0xA5 read data).
  logic [7:0] pat2 = 8'hA5;
  int         busy2_cnt = 0, rise2_cnt = 0, we2_cnt = 0, cyc2 = 0, last_rise2 = 0;
  logic       sclk2_prev = 1'b0, mosi2_prev = 1'b0;
  always @(negedge clk_i) begin
    if (busy2_o) begin
      busy2_cnt++;
      if (sclk2_o && !sclk2_prev) begin
        checkOutput("d2_mosi_stable", mosi2_o, mosi2_prev);
        checkOutput("d2_mosi_bit", mosi2_o, {31'd0, pat2[7 - (rise2_cnt % 8)]});
        if (rise2_cnt % 8 != 0) checkOutput("d2_sclk_period", cyc2 - last_rise2, 2);
        last_rise2 = cyc2;
        rise2_cnt++;
      end
      if (we2_o) begin
        we2_cnt++;
        checkOutput("d2_rx", dat2_o, EXP_RX2);
        checkOutput("d2_addr", addr2_o, we2_cnt - 1);
      end
    end
    sclk2_prev = sclk2_o;
    mosi2_prev = mosi2_o;
    cyc2++;
  end

  task automatic applyStimulus(input logic [31:0] word, input bit disturb);
    int limit, k;
    wb_q.delete();
    busy_cnt  = 0;
    ones_cnt  = 0;
    zeros_cnt = 0;
    mosi_cap  = '0;
    @(negedge clk_i);
    ctrl_i = word;
    @(negedge clk_i);
    ctrl_i[0] = 1'b0;
    checkOutput("busy_rise", busy_o, 1);
    limit = (int'(word[12:4]) + 1) * P + 10;
    k = 0;
    while (busy_o && k < limit) begin
      @(negedge clk_i);
      k++;
      if (disturb && k == 100) begin
        ctrl_i    = $urandom;
        ctrl_i[0] = 1'b0;
        ctrl_i[1] = ~word[1];
      end
      if (disturb && k == 150) ctrl_i[1] = word[1];
    end
    checkOutput("done_in_time", busy_o, 0);
    repeat (3) @(negedge clk_i);
  endtask

  logic [7:0]  exp_multi [4];
  logic [31:0] exp_wb [5];
  logic [31:0] word;
  int          k;

  initial begin
    rst     = 1'b0;
    ctrl_i  = '0;
    ctrl2_i = '0;
    dat2_i  = 8'hA5;
    miso2_i = 1'b1;
    for (int i = 0; i < 512; i++) begin
      mem[i]        = 8'($urandom);
      miso_bytes[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk_i);
    rst = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single byte, cs asserted.
    mem[0]        = 8'hA5;
    miso_bytes[0] = 8'h3C;
    applyStimulus(32'h0000_0003, 1'b0);
    checkOutput("single_busy_len", busy_cnt, 84);
    checkOutput("single_mem0", mem[0], EXP_SINGLE);
    checkOutput("single_mosi_bits", mosi_cap, 8'hA5);
    checkOutput("single_wb_count", wb_q.size(), 2);
    checkOutput("single_wb_last", (wb_q.size() > 0) ? wb_q[wb_q.size() - 1] : 32'hDEAD_BEEF, 32'h0001_0002);

    // Four bytes.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    miso_bytes[0] = 8'hC0; miso_bytes[1] = 8'hC1; miso_bytes[2] = 8'hC2; miso_bytes[3] = 8'hC3;
    exp_multi = LOOPBACK ? '{8'h11, 8'h22, 8'h33, 8'h44} : '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    exp_wb    = '{32'h0001_0031, 32'h0002_0031, 32'h0003_0031, 32'h0004_0031, 32'h0004_0030};
    applyStimulus(32'h0000_0031, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput("multi_mem", mem[i], exp_multi[i]);
    checkOutput("multi_wb_count", wb_q.size(), 5);
    for (int i = 0; i < 5; i++)
      checkOutput("multi_wb", (i < wb_q.size()) ? wb_q[i] : 32'hDEAD_BEEF, exp_wb[i]);

    // all_1s and all_0s together, two bytes: all_1s wins.
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    applyStimulus(32'h0000_001D, 1'b0);
    checkOutput("all1_zero_bits", zeros_cnt, 0);
    checkOutput("all1_one_cycles", ones_cnt, 2 * 16 * CD);

    // send dropped and cs_ctrl toggled while running.
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    applyStimulus(32'h0000_0023, 1'b1);
    checkOutput("disturb_wb_count", wb_q.size(), 4);
    checkOutput("disturb_wb_last", (wb_q.size() > 0) ? wb_q[wb_q.size() - 1] : 32'hDEAD_BEEF, 32'h0003_0022);

    // Randomized transfers.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) begin
        mem[i]        = 8'($urandom);
        miso_bytes[i] = 8'($urandom);
      end
      word       = $urandom;
      word[12:4] = 9'($urandom_range(0, 6));
      word[2]    = ($urandom_range(0, 3) == 0);
      word[3]    = ($urandom_range(0, 3) == 0);
      word[0]    = 1'b1;
      applyStimulus(word, 1'($urandom_range(0, 1)));
      checkOutput("rand_wb_count", wb_q.size(), int'(word[12:4]) + 2);
    end

    // Maximum length: 512 bytes.
    for (int i = 0; i < 512; i++) begin
      mem[i]        = 8'($urandom);
      miso_bytes[i] = 8'($urandom);
    end
    applyStimulus(32'h0000_1FF1, 1'b0);
    checkOutput("max_wb_count", wb_q.size(), 513);
    checkOutput("max_wb_last", (wb_q.size() > 0) ? wb_q[wb_q.size() - 1] : 32'hDEAD_BEEF, 32'h0200_1FF0);

    // Reset during the first byte's shift.
    wb_q.delete();
    @(negedge clk_i);
    ctrl_i = 32'h0000_0031;
    @(negedge clk_i);
    ctrl_i[0] = 1'b0;
    k = 0;
    while (!sclk_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("rst_reached_shift", sclk_o, 1);
    rst = 1'b0;
    @(negedge clk_i);
    checkOutput("rstmid_sclk", sclk_o, 0);
    checkOutput("rstmid_busy", busy_o, 0);
    checkOutput("rstmid_cs", cs_o, 1);
    checkOutput("rstmid_we", we_o, 0);
    rst = 1'b1;
    wb_q.delete();
    repeat (4 * P) @(negedge clk_i);
    checkOutput("rstmid_no_wb", wb_q.size(), 0);

    // CLK_DIV=1 instance, two bytes.
    ctrl2_i = 32'h0000_0011;
    @(negedge clk_i);
    ctrl2_i[0] = 1'b0;
    k = 0;
    while (busy2_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("d2_done_in_time", busy2_o, 0);
    checkOutput("d2_rises", rise2_cnt, 16);
    checkOutput("d2_busy_len", busy2_cnt, 2 * 19 + 1);
    checkOutput("d2_stores", we2_cnt, 2);

    repeat (3) @(negedge clk_i);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_ctrl_fsm.md
Name: spi_ctrl_fsm

Overview:
- Control engine of the SPI peripheral; sits directly downstream of the SPI control register.
- Latches the control word, reads TX bytes from the SPI data memory, and shifts them out in SPI mode 0.
- Stores each received byte back to the same memory address.
- Writes updated status (send cleared, n_rx_end) back through the control register's priority write port.

Parameters:
- CLK_DIV, 5: clk_i cycles per SCLK half-period. SCLK = clk_i/(2*CLK_DIV), i.e. 1 MHz at 10 MHz. Legal range ≥ 1.
- ADDR_W, 9: data memory address width.

Ports:
- clk_i  in  1  system clock, 10 MHz
- rst  in  1  synchronous, active-low reset
- ctrl_i  in  32  control register contents. Layout:
  - [0] send
  - [1] cs_ctrl
  - [2] all_1s
  - [3] all_0s
  - [12:4] n_tx_end
  - [25:16] n_rx_end
  - other bits reserved
- ctrl_o  out  32  write-back value for the control register's priority port
- ctrl_we_o  out  1  one-cycle write strobe for ctrl_o
- addr_o  out  ADDR_W  data memory address
- dat_i  in  8  memory read data, valid the cycle after addr_o (registered read)
- dat_o  out  8  received byte to memory
- we_o  out  1  memory write strobe, one cycle
- sclk_o  out  1  SPI clock, idle low
- mosi_o  out  1  master out
- miso_i  in  1  master in
- cs_o  out  1  chip select, active low; equals ~ctrl_i[1] at all times, registered
- busy_o  out  1  high from leaving IDLE until return to IDLE

Behaviour:
- Reset values (rst=0 at a clk_i edge): state IDLE, all outputs 0 except cs_o=1.
  - Reset mid-transfer aborts immediately.
  - No write-back, no memory write.
  - sclk_o forced low.
- IDLE: when ctrl_i[0]=1, latch ctrl_i into ctrl_q, clear byte counter cnt (10 b) and addr, then go to LOAD. The send bit is sampled only in IDLE; ctrl_i changes during a transfer are ignored.
- LOAD (2 cycles): drive addr_o=cnt; byte source in priority order:
  - all_1s=1 → 0xFF
  - else all_0s=1 → 0x00
  - else dat_i on the second cycle
  - Load into tx shift register; go to SHIFT.
- SHIFT: mode 0, MSB first.
  - mosi_o carries tx[7] for a full half-period before each rising SCLK edge.
  - miso_i is sampled into rx on the rising edge.
  - tx shifts on the falling edge.
  - 8 SCLK periods = 16*CLK_DIV cycles; sclk_o is low on exit. Then go to STORE.
- STORE (1 cycle): we_o=1, addr_o=cnt, dat_o=rx.
  - Same cycle: ctrl_we_o=1, ctrl_o=ctrl_q with [25:16]=cnt+1, [0]=1.
  - cnt++.
  - If the old cnt equals n_tx_end, go to DONE; else go to LOAD.
- DONE (1 cycle): ctrl_we_o=1, ctrl_o=ctrl_q with [0]=0 and [25:16]=n_tx_end+1; then go to IDLE.
- Bytes per transfer = n_tx_end+1, range 1..512.
  - n_tx_end=0 sends exactly one byte.
  - addr wraps mod 2^ADDR_W.
  - cnt never exceeds 512.
- Write-back has priority over software writes in the control register; a software write in a STORE/DONE cycle is lost. This is by design.
- ctrl_we_o is never high in two consecutive cycles, except STORE→DONE on the last byte.
- Total latency for N bytes: N*(3+16*CLK_DIV)+1 cycles from send seen to return to IDLE.
- send still 1 after DONE (software rewrite race): a new transfer starts only once ctrl_i[0]=1 is sampled again in IDLE. Firmware clears the bit and waits.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: miso path internally tied to mosi_o (miso_i ignored); each received byte equals the transmitted byte.
- Undefined: miso_i used directly, with a 2-flop synchronizer. Sampling still occurs on the rising SCLK edge as seen internally.

Test Plan:
- Reset mid-SHIFT: assert rst=0 during byte 1 → next cycle sclk_o=0, busy_o=0, cs_o=1, we_o=0; no ctrl write-back follows.
- Loopback, single byte:
  - Setup: SPI_LOOPBACK_EN defined; mem[0]=0xA5; ctrl_i=0x0000_0003.
  - mosi_o bit sequence 1,0,1,0,0,1,0,1.
  - mem[0] written 0xA5.
  - Final ctrl_o=0x0001_0002 with ctrl_we_o pulse.
  - busy_o high for 84 cycles (CLK_DIV=5).
- Multi-byte:
  - Setup: n_tx_end=3; mem[0..3]=0x11,0x22,0x33,0x44; miso_i driven with 0xC0..0xC3.
  - Memory receives 0xC0..0xC3 at addresses 0..3.
  - Four STORE write-backs carry n_rx_end=1..4 with send=1; DONE carries n_rx_end=4 with send=0.
- all_1s and all_0s both set, n_tx_end=1: mosi_o constant 1 for 16 SCLK periods; memory reads never affect output.
- SCLK timing: CLK_DIV=1 → sclk_o period 2 cycles; exactly 8 rising edges per byte; mosi_o stable across each rising edge.
- ctrl_i send dropped and cs_ctrl toggled mid-transfer: transfer completes unchanged; cs_o follows ~cs_ctrl within one cycle.
